cpu_bus_fabric: RTL



---
 rtl/fabric_pkg.sv | 15 +
 rtl/bus_priority_decode.sv | 29 ++
 rtl/cpu_bus_fabric.sv | 94 +++++++++
 3 files changed

// File: rtl/fabric_pkg.sv
// fabric_pkg: shared constants, FSM state type and default system address map for cpu_bus_fabric
package fabric_pkg;
   localparam int IDX_W = 4;
   localparam logic [IDX_W-1:0] IDX_NONE = 4'hF;
   typedef enum logic {ST_IDLE, ST_WAIT} state_t;
   localparam logic [7:0] RAM_BASE  = 8'h00, RAM_MASK  = 8'h80;
   localparam logic [7:0] VRAM_BASE = 8'h80, VRAM_MASK = 8'hF0;
   localparam logic [7:0] VGA_BASE  = 8'h90, VGA_MASK  = 8'hFF;
   localparam logic [7:0] SSEG_BASE = 8'h91, SSEG_MASK = 8'hFF;
   localparam logic [7:0] UART_BASE = 8'h92, UART_MASK = 8'hFF;
   localparam logic [7:0] KBD_BASE  = 8'h93, KBD_MASK  = 8'hFF;
   localparam logic [7:0] BIOS_BASE = 8'hC0, BIOS_MASK = 8'hC0;
   localparam logic [55:0] MAP_BASE = {BIOS_BASE, KBD_BASE, UART_BASE, SSEG_BASE, VGA_BASE, VRAM_BASE, RAM_BASE};
   localparam logic [55:0] MAP_MASK = {BIOS_MASK, KBD_MASK, UART_MASK, SSEG_MASK, VGA_MASK, VRAM_MASK, RAM_MASK};
endpackage

// File: rtl/bus_priority_decode.sv
// bus_priority_decode: combinational address-MSB region decode, lowest matching index wins
// Ports: msb_i (addr[15:8]), base_i/mask_i (N x 8 packed), hit_o, sel_o (one-hot or zero), idx_o (IDX_NONE on miss)
module bus_priority_decode
   import fabric_pkg::*;
#(
   parameter int N = 7
)(
   input  logic [7:0]       msb_i,
   input  logic [N*8-1:0]   base_i,
   input  logic [N*8-1:0]   mask_i,
   output logic             hit_o,
   output logic [N-1:0]     sel_o,
   output logic [IDX_W-1:0] idx_o
);
   // Scanning from the top down lets the lowest matching index overwrite the others.
   always_comb begin
      hit_o = 1'b0;
      sel_o = '0;
      idx_o = IDX_NONE;
      for (int s = N - 1; s >= 0; s--) begin
         if (((msb_i ^ base_i[8*s+:8]) & mask_i[8*s+:8]) == 8'h00) begin
            hit_o    = 1'b1;
            sel_o    = '0;
            sel_o[s] = 1'b1;
            idx_o    = IDX_W'(s);
         end
      end
   end
endmodule

// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: CPU-side decode, wait-state generation, read-data alignment and unmapped-access logging
// Ports: clk_i/rst_i (sync, active-high), addr_i/we_i from the core, sel_o slave selects,
//        slv_dout_i packed slave read data, cpu_din_o/rdy_o to the core, err_o/err_addr_o/err_cnt_o error log
module cpu_bus_fabric
   import fabric_pkg::*;
#(
   parameter int                      NUM_SLAVES   = 7,
   parameter logic [NUM_SLAVES*8-1:0] SLV_BASE     = MAP_BASE,
   parameter logic [NUM_SLAVES*8-1:0] SLV_MASK     = MAP_MASK,
   parameter logic [NUM_SLAVES*2-1:0] SLV_LAT      = '0,
   parameter logic [7:0]              DEFAULT_DATA = 8'h00
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [15:0]               addr_i,
   input  logic                      we_i,
   output logic [NUM_SLAVES-1:0]     sel_o,
   input  logic [NUM_SLAVES*8-1:0]   slv_dout_i,
   output logic [7:0]                cpu_din_o,
   output logic                      rdy_o,
   output logic                      err_o,
   output logic [15:0]               err_addr_o,
   output logic [7:0]                err_cnt_o
);
   logic             hit, start;
   logic [IDX_W-1:0] idx, idx_q, idx_d;
   logic [1:0]       lat, cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic             err_q, err_d;
   logic [15:0]      err_addr_q, err_addr_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   bus_priority_decode #(.N(NUM_SLAVES)) u_dec (
      .msb_i  (addr_i[15:8]),
      .base_i (SLV_BASE),
      .mask_i (SLV_MASK),
      .hit_o  (hit),
      .sel_o  (sel_o),
      .idx_o  (idx)
   );
   // Latency comes from the live decode; read data comes from the index captured on the completing cycle.
   always_comb begin
      lat       = 2'd0;
      cpu_din_o = DEFAULT_DATA;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (idx == IDX_W'(s)) lat = SLV_LAT[2*s+:2];
         if (idx_q == IDX_W'(s)) cpu_din_o = slv_dout_i[8*s+:8];
      end
   end
   // Output logic: rdy_o depends only on address/we and FSM state, never on slave data.
   always_comb begin
      start = hit && !we_i && lat != 2'd0;
      rdy_o = rst_i || (state_q == ST_IDLE ? !start : cnt_q == 2'd0);
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d = ST_WAIT;
            cnt_d   = lat - 2'd1;
         end
      end else if (cnt_q == 2'd0) begin
         state_d = ST_IDLE;
      end else begin
         cnt_d = cnt_q - 2'd1;
      end
   end
   always_comb begin
      idx_d      = rdy_o ? idx : idx_q;
      err_d      = rdy_o && !hit;
      err_addr_d = err_d ? addr_i : err_addr_q;
      err_cnt_d  = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         idx_q      <= IDX_NONE;
         err_q      <= 1'b0;
         err_addr_q <= 16'h0000;
         err_cnt_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end
   assign err_o      = err_q;
   assign err_addr_o = err_addr_q;
   assign err_cnt_o  = err_cnt_q;
endmodule
